// File: rtl/systolic_edge_feeder_if.sv
// Stream bundle between a tile source and a systolic edge feeder:
// upstream valid/ready vector handshake plus the skewed per-lane outputs.
interface systolic_edge_feeder_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 32
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_data;
   logic [LANES*WIDTH-1:0] out_data;
   logic [LANES-1:0]       out_en;
   logic                   busy;
   logic                   tile_done;

   modport master (
      output in_valid, in_data,
      input  in_ready, out_data, out_en, busy, tile_done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out_data, out_en, busy, tile_done
   );
endinterface

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for the systolic array: accepts a DEPTH-beat tile and re-times it
// into a diagonal wavefront (lane i delayed i cycles). Macro EDGE_FEEDER_BUBBLE_CNT_EN adds bubble_cnt.
module systolic_edge_feeder #(
   parameter int LANES = 4,
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
   output logic [15:0] bubble_cnt,
`endif
   systolic_edge_feeder_if.slave bus
);

   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int DRAIN_W = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(DEPTH - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(LANES - 1);

   typedef enum logic [1:0] {
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic               accept;

   // Ready depends only on state, so accept never loops through the output logic.
   assign bus.in_ready = (state_q == FEED);
   assign accept       = bus.in_valid && (state_q == FEED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FEED;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values; blocking would chain them.
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      drain_cnt_d   = drain_cnt_q;
      bus.busy      = 1'b0;
      bus.tile_done = 1'b0;
      unique case (state_q)
         FEED: begin
            bus.busy = (beat_cnt_q != '0);
            if (accept) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  state_d    = DRAIN;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            bus.busy = 1'b1;
            if (drain_cnt_q == LAST_DRAIN) begin
               drain_cnt_d = '0;
               state_d     = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
         end
         DONE: begin
            bus.tile_done = 1'b1;
            state_d       = FEED;
         end
         default: state_d = FEED;
      endcase
   end

   // Lane i: stage 0 plus i extra stages. Bubbles enter as en=0/data=0 and
   // travel the same diagonal, so a disabled lane never shows stale data.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] data_q [0:i];
      logic [i:0]       en_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: the delay stages are plain flops, not a RAM, so they are reset to blank the edge cells at once.
            en_q <= '0;
            for (int s = 0; s <= i; s++) data_q[s] <= '0;
         end else begin
            en_q[0]   <= accept;
            data_q[0] <= accept ? bus.in_data[i*WIDTH +: WIDTH] : '0;
            for (int s = 1; s <= i; s++) begin
               en_q[s]   <= en_q[s-1];
               data_q[s] <= data_q[s-1];
            end
         end
      end

      assign bus.out_en[i]                  = en_q[i];
      assign bus.out_data[i*WIDTH +: WIDTH] = data_q[i];
   end

`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
   // DONE never overlaps FEED, so a clear cycle can never also count a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (state_q == DONE) begin
         bubble_cnt <= '0;
      end else if (state_q == FEED && bus.busy && !accept && bubble_cnt != 16'hFFFF) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Self-checking bench for systolic_edge_feeder: two lockstep 4x4 instances, one 1x1
// instance, directed scenarios and a randomized run against a timeline model.
module tb_systolic_edge_feeder;
   localparam int LANES = 4;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int BW    = LANES * WIDTH;
   localparam int MAXC  = 4096;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_edge_feeder_if #(.LANES(LANES), .WIDTH(WIDTH)) bus_a ();
   systolic_edge_feeder_if #(.LANES(LANES), .WIDTH(WIDTH)) bus_b ();
   systolic_edge_feeder_if #(.LANES(1), .WIDTH(16))        bus_c ();

   assign bus_b.in_valid = bus_a.in_valid;

`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
   logic [15:0] bub_a, bub_b, bub_c;
`endif

   systolic_edge_feeder #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst_n(rst_n),
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
      .bubble_cnt(bub_a),
`endif
      .bus(bus_a.slave)
   );

   systolic_edge_feeder #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst_n(rst_n),
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
      .bubble_cnt(bub_b),
`endif
      .bus(bus_b.slave)
   );

   systolic_edge_feeder #(.LANES(1), .WIDTH(16), .DEPTH(1)) dut_c (
      .clk(clk), .rst_n(rst_n),
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
      .bubble_cnt(bub_c),
`endif
      .bus(bus_c.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Timeline model: what was accepted in each cycle, plus the tile bookkeeping.
   bit            h_acc [MAXC];
   logic [BW-1:0] h_dat [MAXC];
   int            m_cnt, m_last_t, m_bub;

   logic             e_ready, e_busy, e_done;
   logic [LANES-1:0] e_en;
   logic [BW-1:0]    e_data, e_data_b;
   int               e_bub;

   task automatic model_reset();
      for (int i = 0; i < MAXC; i++) h_acc[i] = 1'b0;
      m_cnt    = 0;
      m_last_t = -1;
      m_bub    = 0;
   endtask

   // Advance one cycle: drive inputs after the edge, predict outputs, return at the negedge.
   task automatic cycle(input logic v, input logic [BW-1:0] d);
      int j;
      bit drain, done;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      bus_a.in_valid = v;
      bus_a.in_data  = d;
      bus_b.in_data  = ~d;
      drain   = (m_last_t >= 0) && (cyc > m_last_t) && (cyc <= m_last_t + LANES);
      done    = (m_last_t >= 0) && (cyc == m_last_t + LANES + 1);
      e_ready = !(drain || done);
      e_done  = done;
      e_busy  = drain || (e_ready && m_cnt != 0);
      e_bub   = m_bub;
      for (int i = 0; i < LANES; i++) begin
         j = cyc - 1 - i;
         e_en[i] = (j >= 0) ? h_acc[j] : 1'b0;
         e_data[i*WIDTH +: WIDTH]   = (j >= 0 && h_acc[j]) ? h_dat[j][i*WIDTH +: WIDTH] : '0;
         e_data_b[i*WIDTH +: WIDTH] = (j >= 0 && h_acc[j]) ? ~h_dat[j][i*WIDTH +: WIDTH] : '0;
      end
      h_acc[cyc] = v && e_ready;
      h_dat[cyc] = d;
      if (done) begin
         m_bub    = 0;
         m_last_t = -1;
      end else if (e_ready && e_busy && !h_acc[cyc] && m_bub < 65535) begin
         m_bub++;
      end
      if (h_acc[cyc]) begin
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_cnt    = 0;
            m_last_t = cyc;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      vectors++;
      if ({bus_a.in_ready, bus_a.busy, bus_a.tile_done} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b exp=100", {bus_a.in_ready, bus_a.busy, bus_a.tile_done});
      end
      vectors++;
      if ({bus_a.out_en, bus_a.out_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_out en=%h data=%h exp=0", bus_a.out_en, bus_a.out_data);
      end
      vectors++;
      if ({bus_c.in_ready, bus_c.busy, bus_c.tile_done, bus_c.out_en} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_c got=%b exp=1000", {bus_c.in_ready, bus_c.busy, bus_c.tile_done, bus_c.out_en});
      end
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
      vectors++;
      if (bub_a !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_bubble got=%0d exp=0", bub_a);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] bv;
      logic        x_en0, x_en3;
      for (int k = 0; k < 12; k++) begin
         bv = 32'h11 * (k + 1);
         cycle(k < 4, {LANES{bv}});
         x_en0 = (k >= 1 && k <= 4);
         x_en3 = (k >= 4 && k <= 7);
         vectors++;
         if ({bus_a.out_en[0], bus_a.out_data[31:0]} !== {x_en0, x_en0 ? 32'h11 * k : 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_lane0 k=%0d got=%b/%h", k, bus_a.out_en[0], bus_a.out_data[31:0]);
         end
         vectors++;
         if ({bus_a.out_en[3], bus_a.out_data[127:96]} !== {x_en3, x_en3 ? 32'h11 * (k - 3) : 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_lane3 k=%0d got=%b/%h", k, bus_a.out_en[3], bus_a.out_data[127:96]);
         end
         vectors++;
         if ({bus_a.in_ready, bus_a.tile_done} !== {!(k >= 4 && k <= 8), k == 8}) begin
            miscompares++;
            $display("FAIL b2b_ctrl k=%0d ready/done got=%b", k, {bus_a.in_ready, bus_a.tile_done});
         end
         vectors++;
         if ({bus_a.busy, bus_a.out_en, bus_a.out_data} !== {e_busy, e_en, e_data}) begin
            miscompares++;
            $display("FAIL b2b_model k=%0d got=%b/%h/%h exp=%b/%h/%h", k, bus_a.busy, bus_a.out_en,
                     bus_a.out_data, e_busy, e_en, e_data);
         end
      end
   endtask

   task automatic test_bubble();
      logic [31:0] bv;
      for (int k = 0; k < 13; k++) begin
         bv = (k < 2) ? 32'h11 * (k + 1) : 32'h11 * k;
         cycle(k == 0 || k == 1 || k == 3 || k == 4, {LANES{bv}});
         for (int i = 0; i < LANES; i++) begin
            if (k == 3 + i) begin
               vectors++;
               if ({bus_a.out_en[i], bus_a.out_data[i*WIDTH +: WIDTH]} !== 33'h0) begin
                  miscompares++;
                  $display("FAIL bubble_gap lane=%0d got=%b/%h exp=0/0", i, bus_a.out_en[i],
                           bus_a.out_data[i*WIDTH +: WIDTH]);
               end
            end
         end
         vectors++;
         if (bus_a.tile_done !== (k == 9)) begin
            miscompares++;
            $display("FAIL bubble_done k=%0d got=%b", k, bus_a.tile_done);
         end
         vectors++;
         if ({bus_a.in_ready, bus_a.busy, bus_a.out_en, bus_a.out_data} !== {e_ready, e_busy, e_en, e_data}) begin
            miscompares++;
            $display("FAIL bubble_model k=%0d got=%h exp=%h", k, bus_a.out_data, e_data);
         end
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
         if (k == 8 || k == 10) begin
            vectors++;
            if (bub_a !== ((k == 8) ? 16'd1 : 16'd0)) begin
               miscompares++;
               $display("FAIL bubble_cnt k=%0d got=%0d exp=%0d", k, bub_a, (k == 8) ? 1 : 0);
            end
         end
`endif
      end
   endtask

   task automatic test_hold_valid();
      logic [31:0] bv;
      for (int k = 0; k < 20; k++) begin
         bv = (k < 4) ? 32'h100 + k : 32'hDEAD;
         cycle(k <= 12, {LANES{bv}});
         if (k >= 4 && k <= 8) begin
            vectors++;
            if (bus_a.in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL hold_ready k=%0d got=%b exp=0", k, bus_a.in_ready);
            end
         end
         if (k >= 5 && k <= 9) begin
            vectors++;
            if (bus_a.out_en[0] !== 1'b0) begin
               miscompares++;
               $display("FAIL hold_no_accept k=%0d lane0 en got=%b exp=0", k, bus_a.out_en[0]);
            end
         end
         if (k == 10) begin
            vectors++;
            if ({bus_a.out_en[0], bus_a.out_data[31:0]} !== {1'b1, 32'hDEAD}) begin
               miscompares++;
               $display("FAIL hold_first_dead got=%b/%h exp=1/0000dead", bus_a.out_en[0], bus_a.out_data[31:0]);
            end
         end
         vectors++;
         if ({bus_a.tile_done, bus_a.busy, bus_a.out_en, bus_a.out_data} !== {e_done, e_busy, e_en, e_data}) begin
            miscompares++;
            $display("FAIL hold_model k=%0d got=%b/%h exp=%b/%h", k, bus_a.tile_done, bus_a.out_data, e_done, e_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] bv;
      for (int k = 0; k < 4; k++) begin
         bv = 32'hA0 + k;
         cycle(k < 3, {LANES{bv}});
         vectors++;
         if (bus_a.out_en !== e_en) begin
            miscompares++;
            $display("FAIL rstmid_pre k=%0d en got=%b exp=%b", k, bus_a.out_en, e_en);
         end
      end
      bus_a.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus_a.out_en, bus_b.out_en} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_async_en got=%b/%b exp=0", bus_a.out_en, bus_b.out_en);
      end
      vectors++;
      if ({bus_a.out_data, bus_b.out_data} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_async_data got=%h exp=0", bus_a.out_data);
      end
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({bus_a.tile_done, bus_a.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_hold done/busy got=%b exp=00", {bus_a.tile_done, bus_a.busy});
         end
      end
      rst_n = 1'b1;
      cyc += 2;
      model_reset();
      #1;
      vectors++;
      if ({bus_a.in_ready, bus_a.busy, bus_a.tile_done} !== 3'b100) begin
         miscompares++;
         $display("FAIL rstmid_release got=%b exp=100", {bus_a.in_ready, bus_a.busy, bus_a.tile_done});
      end
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, '0);
         vectors++;
         if ({bus_a.in_ready, bus_a.busy, bus_a.tile_done, bus_a.out_en} !== {e_ready, e_busy, e_done, e_en}) begin
            miscompares++;
            $display("FAIL rstmid_after k=%0d got=%b exp=%b", k,
                     {bus_a.in_ready, bus_a.busy, bus_a.tile_done, bus_a.out_en}, {e_ready, e_busy, e_done, e_en});
         end
      end
   endtask

   task automatic test_single();
      logic [19:0] exp_c;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, '0);
         exp_c = {!(k == 6 || k == 7), k == 6, k == 7, k == 6, (k == 6) ? 16'hABCD : 16'h0};
         vectors++;
         if ({bus_c.in_ready, bus_c.busy, bus_c.tile_done, bus_c.out_en, bus_c.out_data} !== exp_c) begin
            miscompares++;
            $display("FAIL single k=%0d got=%h exp=%h", k,
                     {bus_c.in_ready, bus_c.busy, bus_c.tile_done, bus_c.out_en, bus_c.out_data}, exp_c);
         end
         bus_c.in_valid = (k == 5);
         bus_c.in_data  = (k == 5) ? 16'hABCD : 16'h0;
      end
   endtask

   task automatic test_random();
      logic [BW-1:0] d;
      for (int k = 0; k < 600; k++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         cycle($urandom_range(0, 9) < 7, d);
         vectors++;
         if ({bus_a.in_ready, bus_a.busy, bus_a.tile_done} !== {e_ready, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc,
                     {bus_a.in_ready, bus_a.busy, bus_a.tile_done}, {e_ready, e_busy, e_done});
         end
         vectors++;
         if ({bus_a.out_en, bus_a.out_data} !== {e_en, e_data}) begin
            miscompares++;
            $display("FAIL rand_lanes cyc=%0d got=%b/%h exp=%b/%h", cyc, bus_a.out_en, bus_a.out_data, e_en, e_data);
         end
         vectors++;
         if ({bus_b.in_ready, bus_b.out_en, bus_b.out_data} !== {e_ready, e_en, e_data_b}) begin
            miscompares++;
            $display("FAIL rand_lockstep cyc=%0d en got=%b exp=%b", cyc, bus_b.out_en, e_en);
         end
`ifdef EDGE_FEEDER_BUBBLE_CNT_EN
         vectors++;
         if ({bub_a, bub_b} !== {e_bub[15:0], e_bub[15:0]}) begin
            miscompares++;
            $display("FAIL rand_bubble cyc=%0d got=%0d/%0d exp=%0d", cyc, bub_a, bub_b, e_bub);
         end
`endif
      end
   endtask

   initial begin
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = '0;
      bus_b.in_data  = '0;
      bus_c.in_valid = 1'b0;
      bus_c.in_data  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      test_reset();
      test_back_to_back();
      test_bubble();
      test_hold_valid();
      test_reset_mid();
      test_single();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
